gcd_ap_driver: RTL and testbench

- Initiator side of the ap_ctrl handshake (ap_start / ap_done / ap_return) used by our HLS-style kernels such as gcd.
- Accepts operand pairs on a valid/ready slave port and resets the kernel between jobs, because a kernel holds ap_done sticky until reset.
- Drives k_start and stable operands, waits for k_done, captures k_return, and presents the result on a valid/ready master port.
- Sits between the test/SoC fabric and one kernel instance.

---
 rtl/gcd_ap_pkg.sv | 23 ++
 rtl/gcd_ap_watchdog.sv | 43 ++++
 rtl/gcd_ap_driver.sv | 148 ++++++++++++++
 tb/tb_gcd_ap_driver.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_ap_pkg.sv
// gcd_ap_pkg
// Constants and types shared by the ap_ctrl initiator (gcd_ap_driver), its
// optional watchdog, and the HLS-style kernels it drives.
//   GCD_KERNEL_DATA_W : data width of the kernel ap_ctrl interface
//   GCD_AP_DATA_W     : default operand/result width of the driver
//   GCD_AP_RST_CYCLES : default kernel reset length before each job
//   GCD_AP_TIMEOUT    : default WAIT-state cycle limit (watchdog build only)
//   gcd_ap_state_e    : driver FSM states
package gcd_ap_pkg;

  localparam int unsigned GCD_KERNEL_DATA_W = 32;
  localparam int unsigned GCD_AP_DATA_W     = GCD_KERNEL_DATA_W;
  localparam int unsigned GCD_AP_RST_CYCLES = 2;
  localparam int unsigned GCD_AP_TIMEOUT    = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KRST = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } gcd_ap_state_e;

endpackage

// File: rtl/gcd_ap_watchdog.sv
// gcd_ap_watchdog
// WAIT-state cycle counter for gcd_ap_driver. Only built when the macro
// GCD_AP_DRIVER_TIMEOUT_EN is defined.
// Ports:
//   ap_clk  : clock, rising edge
//   ap_rst  : asynchronous active-high reset
//   clear   : restart the count (pulsed on the edge that enters WAIT)
//   enable  : high while the driver is in WAIT
//   expired : high in the WAIT cycle whose edge completes TIMEOUT WAIT cycles
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
module gcd_ap_watchdog
  import gcd_ap_pkg::*;
#(
  parameter int unsigned TIMEOUT = GCD_AP_TIMEOUT
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  // The count holds the number of WAIT edges already seen, so the edge
  // that sees WD_LAST is the TIMEOUT-th one.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wd_cnt <= '0;
    end else if (clear) begin
      wd_cnt <= '0;
    end else if (enable && (wd_cnt != WD_LAST)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign expired = enable && (wd_cnt == WD_LAST);

endmodule
`endif

// File: rtl/gcd_ap_driver.sv
// gcd_ap_driver
// Initiator side of the ap_ctrl handshake for one HLS-style kernel (e.g. gcd).
// Takes an operand pair, resets the kernel for RST_CYCLES cycles (a kernel
// keeps ap_done sticky until reset), starts it with stable operands, waits
// for k_done, captures k_return and offers it on the result port.
// Optional feature macro: GCD_AP_DRIVER_TIMEOUT_EN adds a WAIT watchdog and
// the m_err port; a timed-out job returns m_result=0 with m_err=1.
// Ports:
//   ap_clk, ap_rst          : clock / asynchronous active-high reset
//   s_valid, s_ready, s_a, s_b : operand pair slave port
//   m_valid, m_ready, m_result : result master port
//   k_rst_n, k_start, k_a, k_b : kernel reset, ap_start and operands
//   k_done, k_return        : kernel ap_done (level) and ap_return
//   busy                    : high in any state other than IDLE
//   m_err                   : timeout flag (watchdog build only)
//   dbg_state               : current FSM state (gcd_ap_state_e encoding)
// Handshake rule on both ports: a transfer happens on a rising edge where
// valid and ready are both high; once valid is raised the payload stays
// stable until that transfer edge.
module gcd_ap_driver
  import gcd_ap_pkg::*;
#(
  parameter int unsigned DATA_W     = GCD_AP_DATA_W,
  parameter int unsigned RST_CYCLES = GCD_AP_RST_CYCLES,
  parameter int unsigned TIMEOUT    = GCD_AP_TIMEOUT
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_result,
  output logic              k_rst_n,
  output logic              k_start,
  output logic [DATA_W-1:0] k_a,
  output logic [DATA_W-1:0] k_b,
  input  logic              k_done,
  input  logic [DATA_W-1:0] k_return,
  output logic              busy,
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
  output logic              m_err,
`endif
  output logic [1:0]        dbg_state
);

  localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);
  // KRST is entered with the counter at 0; the edge that sees RST_LAST is
  // the RST_CYCLES-th edge after the accept edge.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  gcd_ap_state_e    state;
  logic [CNT_W-1:0] rst_cnt;
  logic             krst_last;

  assign krst_last = (state == ST_KRST) && (rst_cnt == RST_LAST);
  assign s_ready   = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

`ifdef GCD_AP_DRIVER_TIMEOUT_EN
  logic wd_expired;

  gcd_ap_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .clear   (krst_last),
    .enable  (state == ST_WAIT),
    .expired (wd_expired)
  );
`else
  // TIMEOUT only has a meaning when the watchdog is built in.
  if (TIMEOUT == 0) begin : g_no_watchdog
  end
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= ST_IDLE;
      m_valid  <= 1'b0;
      m_result <= '0;
      k_start  <= 1'b0;
      k_rst_n  <= 1'b0;
      k_a      <= '0;
      k_b      <= '0;
      rst_cnt  <= '0;
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
      m_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          k_rst_n <= 1'b0;
          k_start <= 1'b0;
          if (s_valid) begin
            k_a     <= s_a;
            k_b     <= s_b;
            rst_cnt <= '0;
            state   <= ST_KRST;
          end
        end
        ST_KRST: begin
          if (krst_last) begin
            k_rst_n <= 1'b1;
            k_start <= 1'b1;
            state   <= ST_WAIT;
          end else begin
            rst_cnt <= rst_cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          // A done seen on the same edge as expiry takes priority.
          if (k_done) begin
            m_result <= k_return;
            m_valid  <= 1'b1;
            k_start  <= 1'b0;
            state    <= ST_RESP;
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
            m_err    <= 1'b0;
          end else if (wd_expired) begin
            m_result <= '0;
            m_valid  <= 1'b1;
            m_err    <= 1'b1;
            k_start  <= 1'b0;
            state    <= ST_RESP;
`endif
          end
        end
        ST_RESP: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            k_rst_n <= 1'b0;
            state   <= ST_IDLE;
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
            m_err   <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ap_driver.sv
// tb_gcd_ap_driver
// Bench for gcd_ap_driver: a behavioural gcd kernel (Euclid, configurable
// latency, optional hang), per-scenario tasks with inline comparisons, and
// an expected-result queue filled on accept and drained on result handshake.
module tb_gcd_ap_driver;
  import gcd_ap_pkg::*;

  localparam int W    = 32;
  localparam int RSTC = 2;
  localparam int TMO  = 64;

  // ---------------- clock / reset ----------------
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  // ---------------- DUT signals ----------------
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_a = '0;
  logic [W-1:0] s_b = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_result;
  logic         k_rst_n;
  logic         k_start;
  logic [W-1:0] k_a;
  logic [W-1:0] k_b;
  logic         k_done;
  logic [W-1:0] k_return;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
  logic         m_err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  gcd_ap_driver #(
    .DATA_W     (W),
    .RST_CYCLES (RSTC),
    .TIMEOUT    (TMO)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_a       (s_a),
    .s_b       (s_b),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_result  (m_result),
    .k_rst_n   (k_rst_n),
    .k_start   (k_start),
    .k_a       (k_a),
    .k_b       (k_b),
    .k_done    (k_done),
    .k_return  (k_return),
    .busy      (busy),
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
    .m_err     (m_err),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- reference gcd ----------------
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // ---------------- kernel model ----------------
  // Done rises k_latency cycles after k_start is first seen high and stays
  // high until the kernel is reset.
  int   k_latency    = 1;
  bit   k_hang       = 1'b0;
  int   kcnt         = 0;
  logic k_done_model = 1'b0;
  logic k_done_force = 1'b0;
  logic [W-1:0] k_ret_model = '0;

  assign k_done   = k_done_model | k_done_force;
  assign k_return = k_ret_model;

  always @(posedge ap_clk or negedge k_rst_n) begin
    if (!k_rst_n) begin
      k_done_model <= 1'b0;
      kcnt         <= 0;
    end else if (k_start && !k_done_model && !k_hang) begin
      if (kcnt == k_latency - 1) begin
        k_done_model <= 1'b1;
        k_ret_model  <= gcd_ref(k_a, k_b);
      end
      kcnt <= kcnt + 1;
    end
  end

  // ---------------- driver / checker for one job ----------------
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                         input int stall, input bit hang, input bit force_early);
    int cyc;
    int exp_cyc;
    bit exp_err;
    logic [W-1:0] exp_r;
    k_latency = lat;
    k_hang    = hang;
    exp_err   = hang;
    exp_cyc   = hang ? TMO : lat + 1;
    exp_r     = hang ? '0 : gcd_ref(a, b);

    cyc = 0;
    while (s_ready !== 1'b1 && cyc < 100) begin
      @(posedge ap_clk); #1; cyc++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++; $display("FAIL idle_wait: s_ready=%b required 1", s_ready);
    end

    if (force_early) begin
      k_done_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge ap_clk); #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
          failures++; $display("FAIL done_in_idle: s_ready=%b m_valid=%b required 1/0", s_ready, m_valid);
        end
      end
    end

    s_valid = 1'b1; s_a = a; s_b = b;
    exp_q.push_back(exp_r);
    @(posedge ap_clk); #1;
    s_valid = 1'b0; s_a = $urandom; s_b = $urandom;

    // kernel reset phase
    cyc = 0;
    while (k_start !== 1'b1 && cyc < RSTC + 10) begin
      checks++;
      if (k_rst_n !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
        failures++;
        $display("FAIL krst_hold: k_rst_n=%b busy=%b s_ready=%b m_valid=%b required 0/1/0/0", k_rst_n, busy, s_ready, m_valid);
      end
      m_ready = 1'($urandom_range(0, 1));
      @(posedge ap_clk); #1; cyc++;
    end
    k_done_force = 1'b0;
    checks++;
    if (cyc !== RSTC) begin
      failures++; $display("FAIL krst_len: got %0d cycles required %0d", cyc, RSTC);
    end

    // kernel running
    cyc = 0;
    while (m_valid !== 1'b1 && cyc < exp_cyc + 20) begin
      checks++;
      if (k_start !== 1'b1 || k_rst_n !== 1'b1 || k_a !== a || k_b !== b) begin
        failures++;
        $display("FAIL wait_hold: k_start=%b k_rst_n=%b k_a=%0h k_b=%0h required 1/1/%0h/%0h", k_start, k_rst_n, k_a, k_b, a, b);
      end
      m_ready = 1'($urandom_range(0, 1));
      @(posedge ap_clk); #1; cyc++;
    end
    checks++;
    if (cyc !== exp_cyc) begin
      failures++; $display("FAIL done_latency: got %0d cycles required %0d", cyc, exp_cyc);
    end
    checks++;
    if (k_start !== 1'b0 || k_rst_n !== 1'b1 || k_a !== a || k_b !== b) begin
      failures++;
      $display("FAIL resp_kernel: k_start=%b k_rst_n=%b k_a=%0h k_b=%0h required 0/1/%0h/%0h", k_start, k_rst_n, k_a, k_b, a, b);
    end
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
    checks++;
    if (m_err !== exp_err) begin
      failures++; $display("FAIL m_err: got %b required %b", m_err, exp_err);
    end
`else
    if (exp_err) $display("note: hang job requested without watchdog build");
`endif

    // back-pressure with a competing operand pair
    m_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      s_valid = 1'b1; s_a = 35; s_b = 14;
      @(posedge ap_clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_result !== exp_q[0] || s_ready !== 1'b0 || k_a !== a || k_b !== b) begin
        failures++;
        $display("FAIL resp_hold: m_valid=%b m_result=%0h s_ready=%b k_a=%0h k_b=%0h required 1/%0h/0/%0h/%0h",
                 m_valid, m_result, s_ready, k_a, k_b, exp_q[0], a, b);
      end
    end
    s_valid = 1'b0;

    // result handshake, scoreboard compare
    checks++;
    exp_r = exp_q.pop_front();
    if (m_result !== exp_r) begin
      failures++; $display("FAIL result: got %0h required %0h", m_result, exp_r);
    end
    m_ready = 1'b1;
    @(posedge ap_clk); #1;
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1 || k_rst_n !== 1'b0 || k_start !== 1'b0 ||
        dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL after_handshake: m_valid=%b busy=%b s_ready=%b k_rst_n=%b k_start=%b state=%0d required 0/0/1/0/0/0",
               m_valid, busy, s_ready, k_rst_n, k_start, dbg_state);
    end
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
    checks++;
    if (m_err !== 1'b0) begin
      failures++; $display("FAIL m_err_clear: got %b required 0", m_err);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || k_rst_n !== 1'b0 || k_start !== 1'b0 || busy !== 1'b0 ||
        m_result !== '0 || k_a !== '0 || k_b !== '0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b k_rst_n=%b k_start=%b busy=%b m_result=%0h k_a=%0h k_b=%0h state=%0d",
               s_ready, m_valid, k_rst_n, k_start, busy, m_result, k_a, k_b, dbg_state);
    end
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
    checks++;
    if (m_err !== 1'b0) begin
      failures++; $display("FAIL reset_m_err: got %b required 0", m_err);
    end
`endif
  endtask

  task automatic test_basic;
    run_job(48, 18, 20, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_job(48, 18, 20, 10, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_job(48, 18, 20, 0, 1'b0, 1'b0);
    run_job(35, 14, 20, 0, 1'b0, 1'b0);
  endtask

  task automatic test_done_ignored;
    run_job(35, 14, 5, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_wait;
    int cyc;
    k_latency = 200;
    k_hang    = 1'b0;
    s_valid = 1'b1; s_a = 48; s_b = 18;
    @(posedge ap_clk); #1;
    s_valid = 1'b0;
    cyc = 0;
    while (k_start !== 1'b1 && cyc < 20) begin
      @(posedge ap_clk); #1; cyc++;
    end
    repeat (5) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    #1;
    checks++;
    if (k_rst_n !== 1'b0 || k_start !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || k_a !== '0) begin
      failures++;
      $display("FAIL reset_mid_wait: k_rst_n=%b k_start=%b m_valid=%b busy=%b k_a=%0h required 0/0/0/0/0",
               k_rst_n, k_start, m_valid, busy, k_a);
    end
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    run_job(35, 14, 20, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      b = (n < 5) ? W'($urandom_range(1, 5000)) * W'($urandom_range(1, 40)) : $urandom;
      run_job(a, b, $urandom_range(1, 30), $urandom_range(0, 4), 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef GCD_AP_DRIVER_TIMEOUT_EN
  task automatic test_timeout;
    run_job(48, 18, 20, 3, 1'b1, 1'b0);
    run_job(35, 14, 10, 0, 1'b0, 1'b0);
  endtask
`endif

  // ---------------- run ----------------
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_done_ignored;
    test_reset_mid_wait;
    test_random;
`ifdef GCD_AP_DRIVER_TIMEOUT_EN
    test_timeout;
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d results left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1, "bench time limit reached");
  end

endmodule
